// File: rtl/pipe_stall_ctrl_if.sv
// Stall/flush handshake bundle between the pipeline datapath and pipe_stall_ctrl.
// master = pipeline side (raises requests), slave = controller side (returns hold/flush).
interface pipe_stall_ctrl_if #(
  parameter int CNT_W = 6
);
  logic             id_stallreq;
  logic             ex_start;
  logic [CNT_W-1:0] ex_cycles;
  logic             flush_req;
  logic [5:0]       stall;
  logic             id_ex_bubble;
  logic             flush;
  logic             ex_busy;
  logic             ex_done;

  modport master (
    output id_stallreq, ex_start, ex_cycles, flush_req,
    input  stall, id_ex_bubble, flush, ex_busy, ex_done
  );

  modport slave (
    input  id_stallreq, ex_start, ex_cycles, flush_req,
    output stall, id_ex_bubble, flush, ex_busy, ex_done
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller: per-stage hold vector, load-use bubble, mul/div sequencing.
// Optional macro PIPE_STALL_CTRL_PERF_EN adds saturating stall_cycles/flush_count counters.
module pipe_stall_ctrl #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
`ifdef PIPE_STALL_CTRL_PERF_EN
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count,
`endif
  pipe_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_LU = 6'b000111;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       stall;
  logic             bubble, flush, busy, done;

  // state register: resetn is an active-high asynchronous reset
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = '0;
    bubble  = 1'b0;
    flush   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    if (resetn) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      busy = (state_q == BUSY);
      if (bus.flush_req) begin
        // flush kills any in-flight op; a same-cycle ex_start is dropped
        flush   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.ex_start) begin
              stall = STALL_EX;
              if (bus.ex_cycles <= CNT_W'(1)) begin
                state_d = DONE;
              end else begin
                cnt_d   = bus.ex_cycles - CNT_W'(1);
                state_d = BUSY;
              end
            end else if (bus.id_stallreq) begin
              stall  = STALL_LU;
              bubble = 1'b1;
            end
          end
          BUSY: begin
            stall = STALL_EX;
            if (cnt_q >= CNT_W'(2)) begin
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              cnt_d   = '0;
              state_d = DONE;
            end
          end
          DONE: begin
            done    = 1'b1;
            state_d = IDLE;
            if (bus.id_stallreq) begin
              stall  = STALL_LU;
              bubble = 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.id_ex_bubble = bubble;
  assign bus.flush        = flush;
  assign bus.ex_busy      = busy;
  assign bus.ex_done      = done;

`ifdef PIPE_STALL_CTRL_PERF_EN
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall[0]) stall_cycles <= sat_inc(stall_cycles);
      if (flush)    flush_count  <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed cycle table plus randomized run
// against a timeline-based reference model.
module tb_pipe_stall_ctrl;
  localparam int CNT_W  = 6;
  localparam int PERF_W = 32;

  logic clk;
  logic resetn;
`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles, flush_count;
`endif

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .resetn       (resetn),
`ifdef PIPE_STALL_CTRL_PERF_EN
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
`endif
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       idr;
    logic       st;
    logic [5:0] n;
    logic       fl;
    logic [5:0] es;
    logic       eb;
    logic       ef;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   passed = 0;

  function automatic vec_t mk(input logic rst, idr, st, input logic [5:0] n, input logic fl,
                              input logic [5:0] es, input logic eb, ef, ebusy, edone);
    vec_t v;
    v.rst = rst; v.idr = idr; v.st = st; v.n = n; v.fl = fl;
    v.es = es; v.eb = eb; v.ef = ef; v.ebusy = ebusy; v.edone = edone;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic apply(input logic rst, idr, st, input logic [5:0] n, input logic fl);
    @(posedge clk);
    #1;
    resetn          = rst;
    bus.id_stallreq = idr;
    bus.ex_start    = st;
    bus.ex_cycles   = n;
    bus.flush_req   = fl;
    @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input logic [5:0] es, input logic eb, ef, ebusy, edone);
    chk({tag, ".stall"},  int'(bus.stall), int'(es));
    chk({tag, ".bubble"}, int'(bus.id_ex_bubble), int'(eb));
    chk({tag, ".flush"},  int'(bus.flush), int'(ef));
    chk({tag, ".busy"},   int'(bus.ex_busy), int'(ebusy));
    chk({tag, ".done"},   int'(bus.ex_done), int'(edone));
  endtask

  // reference timeline: an op started at cycle t with length L stalls t..t+L-1, completes at t+L
  int cyc, stall_until, done_at;
  int m_stalls, m_flushes;

  initial begin
    resetn = 1'b1;
    bus.id_stallreq = 1'b0;
    bus.ex_start = 1'b0;
    bus.ex_cycles = '0;
    bus.flush_req = 1'b0;

    //            rst idr st  n  fl  stall  bub fl busy done
    tbl.push_back(mk(1, 1, 1, 5, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 6'h07, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 5, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 7, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 6'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 8, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 2, 1, 6'h00, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h0F, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 6'h00, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 6, 0, 6'h0F, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0));

    m_stalls = 0;
    m_flushes = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].idr, tbl[i].st, tbl[i].n, tbl[i].fl);
      chk_outs($sformatf("vec%0d", i), tbl[i].es, tbl[i].eb, tbl[i].ef, tbl[i].ebusy, tbl[i].edone);
`ifdef PIPE_STALL_CTRL_PERF_EN
      if (tbl[i].rst) begin m_stalls = 0; m_flushes = 0; end
      chk($sformatf("vec%0d.stall_cycles", i), int'(stall_cycles), m_stalls);
      chk($sformatf("vec%0d.flush_count", i), int'(flush_count), m_flushes);
      if (!tbl[i].rst) begin
        m_stalls  += int'(tbl[i].es[0]);
        m_flushes += int'(tbl[i].ef);
      end
`endif
    end

    // randomized run against the timeline model
    cyc = 0; stall_until = 0; done_at = -1; m_stalls = 0; m_flushes = 0;
    apply(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    cyc++;
    for (int k = 0; k < 400; k++) begin
      logic r, idr, st, fl, in_op, is_done, start;
      logic [5:0] n, es;
      logic eb, ef, eby, edn;
      r   = ($urandom_range(63) == 0);
      idr = ($urandom_range(2) == 0);
      st  = ($urandom_range(2) == 0);
      fl  = ($urandom_range(15) == 0);
      n   = 6'($urandom_range(9));
      apply(r, idr, st, n, fl);
      es = '0; eb = 0; ef = 0; eby = 0; edn = 0;
      if (r) begin
        stall_until = 0; done_at = -1;
        m_stalls = 0; m_flushes = 0;
      end else begin
        in_op   = (cyc < stall_until);
        is_done = (cyc == done_at);
        eby     = in_op;
        if (fl) begin
          ef = 1; stall_until = 0; done_at = -1;
        end else begin
          start = !in_op && !is_done && st;
          edn   = is_done;
          if (in_op || start) es = 6'h0F;
          else if (idr) begin es = 6'h07; eb = 1; end
          if (start) begin
            stall_until = cyc + ((n == 0) ? 1 : int'(n));
            done_at     = stall_until;
          end
        end
      end
      chk_outs($sformatf("rnd%0d", k), es, eb, ef, eby, edn);
`ifdef PIPE_STALL_CTRL_PERF_EN
      chk($sformatf("rnd%0d.stall_cycles", k), int'(stall_cycles), m_stalls);
      chk($sformatf("rnd%0d.flush_count", k), int'(flush_count), m_flushes);
      if (!r) begin
        m_stalls  += int'(es[0]);
        m_flushes += int'(ef);
      end
`endif
      cyc++;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
